// File: rtl/u712_pkg.sv
// Shared types and constants for the U712 CPU-to-chipset register cycle sequencer.
// Optional feature macro used by the design: REG_TIMEOUT_EN.
package u712_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SLOT = 2'd2,
    ACK  = 2'd3
  } state_e;

  localparam int TIMEOUT_SLOTS_DEFAULT = 16;
  localparam int CNT_W                 = 5;

endpackage

// File: rtl/u712_clk_edge.sv
// Brings one asynchronous chip clock into the CLK40 domain and reports its edges.
// The pulses come straight from flops, so no input reaches them combinationally.
module u712_clk_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic last_q;

  // Two synchronizer stages, then a delayed copy so edges can be compared
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~last_q;
  assign fall_o = ~sync2_q & last_q;

endmodule

// File: rtl/u712_chip_reg_cycle.sv
// CPU-to-chipset register cycle sequencer: waits for a chip slot that DMA has not
// claimed, drives the register strobes for that slot and acknowledges the CPU.
// Define REG_TIMEOUT_EN to add the free-slot wait limit and the TEAn output.
module u712_chip_reg_cycle
  import u712_pkg::*;
#(
  parameter int TIMEOUT_SLOTS = TIMEOUT_SLOTS_DEFAULT
) (
  input  logic CLK40,
  input  logic RESET,
  input  logic C1,
  input  logic C3,
  input  logic TSn,
  input  logic REGSPACEn,
  input  logic RnW,
  input  logic DMA_CYCLE,
  output logic CPU_SLOT,
  output logic RGAENn,
  output logic REGWRn,
  output logic DRDLE,
`ifdef REG_TIMEOUT_EN
  output logic TEAn,
`endif
  output logic TACKn
);

  // The slot counter has to be able to hold the limit it is compared against
  if (TIMEOUT_SLOTS < 1 || TIMEOUT_SLOTS >= (1 << CNT_W)) begin : gBadTimeout
    $error("TIMEOUT_SLOTS does not fit the chip slot counter");
  end

  logic c1Rise, c3Fall;
  logic unusedC1Fall, unusedC3Rise;

  state_e state_q, state_d;
  logic   rd_q, rd_d;
  logic   cpuSlot_q, cpuSlot_d;
  logic   rgaen_q, rgaen_d;
  logic   regwr_q, regwr_d;
  logic   drdle_q, drdle_d;
  logic   tack_q, tack_d;
`ifdef REG_TIMEOUT_EN
  logic             tea_q, tea_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  u712_clk_edge uC1Edge (
    .clk_i  (CLK40),
    .rst_i  (RESET),
    .pin_i  (C1),
    .rise_o (c1Rise),
    .fall_o (unusedC1Fall)
  );

  u712_clk_edge uC3Edge (
    .clk_i  (CLK40),
    .rst_i  (RESET),
    .pin_i  (C3),
    .rise_o (unusedC3Rise),
    .fall_o (c3Fall)
  );

  // Next state and next output values; strobes follow the state being entered
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    drdle_d = 1'b0;
    tack_d  = 1'b1;
`ifdef REG_TIMEOUT_EN
    tea_d   = 1'b1;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!TSn && !REGSPACEn) begin
          rd_d    = RnW;
          state_d = WAIT;
`ifdef REG_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (c1Rise) begin
          if (!DMA_CYCLE) begin
            state_d = SLOT;
          end
`ifdef REG_TIMEOUT_EN
          else if (cnt_q + 1'b1 == CNT_W'(TIMEOUT_SLOTS)) begin
            tea_d   = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      SLOT: begin
        if (c3Fall) begin
          drdle_d = rd_q;
          state_d = ACK;
        end
      end
      ACK: begin
        tack_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cpuSlot_d = (state_d == SLOT);
    rgaen_d   = ~cpuSlot_d;
    regwr_d   = ~(cpuSlot_d & ~rd_d);
  end

  // State and registered outputs; reset forces every strobe inactive at once
  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      cpuSlot_q <= 1'b0;
      rgaen_q   <= 1'b1;
      regwr_q   <= 1'b1;
      drdle_q   <= 1'b0;
      tack_q    <= 1'b1;
`ifdef REG_TIMEOUT_EN
      tea_q     <= 1'b1;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      cpuSlot_q <= cpuSlot_d;
      rgaen_q   <= rgaen_d;
      regwr_q   <= regwr_d;
      drdle_q   <= drdle_d;
      tack_q    <= tack_d;
`ifdef REG_TIMEOUT_EN
      tea_q     <= tea_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign CPU_SLOT = cpuSlot_q;
  assign RGAENn   = rgaen_q;
  assign REGWRn   = regwr_q;
  assign DRDLE    = drdle_q;
  assign TACKn    = tack_q;
`ifdef REG_TIMEOUT_EN
  assign TEAn     = tea_q;
`endif

endmodule

// File: tb/tb_u712_chip_reg_cycle.sv
// Directed bench for u712_chip_reg_cycle. C1/C3 come from a 12-clock slot generator
// aligned to CLK40 so every latency is a fixed, hand-computed clock count.
// Build with REG_TIMEOUT_EN defined to also exercise the TEAn path.
module tb_u712_chip_reg_cycle;

  logic CLK40 = 1'b0;
  logic RESET = 1'b1;
  logic TSn = 1'b1;
  logic REGSPACEn = 1'b1;
  logic RnW = 1'b1;
  logic C1, C3, DMA_CYCLE;
  logic CPU_SLOT, RGAENn, REGWRn, DRDLE, TACKn;
`ifdef REG_TIMEOUT_EN
  logic TEAn;
  int teaFirst, teaCnt;
`endif

  int assertCount = 0;
  int failCount = 0;

  logic genRun = 1'b0;
  int ph = 11;
  int slotIdx = 0;
  int dmaUntil = 0;

  int slotFirst, slotCnt, rgaCnt, wrFirst, wrCnt, drdFirst, drdCnt, tackFirst, tackCnt;

  u712_chip_reg_cycle #(.TIMEOUT_SLOTS(4)) dut (
    .CLK40     (CLK40),
    .RESET     (RESET),
    .C1        (C1),
    .C3        (C3),
    .TSn       (TSn),
    .REGSPACEn (REGSPACEn),
    .RnW       (RnW),
    .DMA_CYCLE (DMA_CYCLE),
    .CPU_SLOT  (CPU_SLOT),
    .RGAENn    (RGAENn),
    .REGWRn    (REGWRn),
    .DRDLE     (DRDLE),
`ifdef REG_TIMEOUT_EN
    .TEAn      (TEAn),
`endif
    .TACKn     (TACKn)
  );

  always #5 CLK40 = ~CLK40;

  // Chip slot generator: C1 high for phases 0-5, C3 high for phases 3-8
  always @(negedge CLK40) begin
    if (genRun) begin
      ph <= (ph == 11) ? 0 : ph + 1;
      if (ph == 11) slotIdx <= slotIdx + 1;
    end
  end

  assign C1 = genRun && (ph < 6);
  assign C3 = genRun && (ph >= 3) && (ph < 9);
  assign DMA_CYCLE = (slotIdx < dmaUntil);

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic waitPhase(input int p);
    int guard = 0;
    do begin
      @(negedge CLK40);
      #1;
      guard++;
    end while (ph != p && guard < 30);
    checkOutput("phaseSync", ph, p);
  endtask

  // Launches a transfer start so that it is sampled on the edge labelled phase p
  task automatic applyStimulus(input int p, input logic regSpace, input logic rnw);
    waitPhase(p);
    REGSPACEn = regSpace;
    RnW = rnw;
    TSn = 1'b0;
  endtask

  // Samples outputs after each of n edges; index 0 is the edge that saw TSn low
  task automatic watch(input int n);
    slotFirst = -1; slotCnt = 0; rgaCnt = 0; wrFirst = -1; wrCnt = 0;
    drdFirst = -1; drdCnt = 0; tackFirst = -1; tackCnt = 0;
`ifdef REG_TIMEOUT_EN
    teaFirst = -1; teaCnt = 0;
`endif
    for (int i = 0; i < n; i++) begin
      @(negedge CLK40);
      #1;
      if (i == 0) begin
        TSn = 1'b1;
        REGSPACEn = 1'b1;
        RnW = ~RnW;
      end
      if (CPU_SLOT === 1'b1) begin if (slotFirst < 0) slotFirst = i; slotCnt++; end
      if (RGAENn === 1'b0) rgaCnt++;
      if (REGWRn === 1'b0) begin if (wrFirst < 0) wrFirst = i; wrCnt++; end
      if (DRDLE === 1'b1) begin if (drdFirst < 0) drdFirst = i; drdCnt++; end
      if (TACKn === 1'b0) begin if (tackFirst < 0) tackFirst = i; tackCnt++; end
`ifdef REG_TIMEOUT_EN
      if (TEAn === 1'b0) begin if (teaFirst < 0) teaFirst = i; teaCnt++; end
`endif
    end
  endtask

  task automatic checkRun(input string tag, input int eSlotFirst, input int eSlotCnt,
                          input int eWrFirst, input int eWrCnt, input int eDrdFirst,
                          input int eDrdCnt, input int eTackFirst, input int eTackCnt);
    checkOutput({tag, ".slotFirst"}, slotFirst, eSlotFirst);
    checkOutput({tag, ".slotCnt"}, slotCnt, eSlotCnt);
    checkOutput({tag, ".rgaenCnt"}, rgaCnt, eSlotCnt);
    checkOutput({tag, ".wrFirst"}, wrFirst, eWrFirst);
    checkOutput({tag, ".wrCnt"}, wrCnt, eWrCnt);
    checkOutput({tag, ".drdFirst"}, drdFirst, eDrdFirst);
    checkOutput({tag, ".drdCnt"}, drdCnt, eDrdCnt);
    checkOutput({tag, ".tackFirst"}, tackFirst, eTackFirst);
    checkOutput({tag, ".tackCnt"}, tackCnt, eTackCnt);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge CLK40);
    #1;
    checkOutput("rst.CPU_SLOT", CPU_SLOT, 0);
    checkOutput("rst.RGAENn", RGAENn, 1);
    checkOutput("rst.REGWRn", REGWRn, 1);
    checkOutput("rst.DRDLE", DRDLE, 0);
    checkOutput("rst.TACKn", TACKn, 1);
`ifdef REG_TIMEOUT_EN
    checkOutput("rst.TEAn", TEAn, 1);
`endif
    RESET = 1'b0;
    genRun = 1'b1;
    repeat (4) @(negedge CLK40);

    // Read, no DMA: slot at next C1R (+9), C3F at +18, ack at +19
    applyStimulus(5, 1'b0, 1'b1);
    watch(40);
    checkRun("read", 9, 9, -1, 0, 18, 1, 19, 1);

    // Write with three DMA-owned slots: slot entered on fourth C1R (+45)
    applyStimulus(5, 1'b0, 1'b0);
    dmaUntil = slotIdx + 4;
    watch(70);
    checkRun("writeDma", 45, 9, 45, 9, -1, 0, 55, 1);

    // Transfer start outside register space is ignored
    applyStimulus(5, 1'b1, 1'b1);
    watch(40);
    checkRun("notReg", -1, 0, -1, 0, -1, 0, -1, 0);

    // Transfer start on the C1R edge: that slot is skipped
    applyStimulus(2, 1'b0, 1'b1);
    watch(40);
    checkRun("tsOnC1R", 12, 9, -1, 0, 21, 1, 22, 1);

    // Reset in the middle of a write slot
    applyStimulus(5, 1'b0, 1'b0);
    for (int i = 0; i <= 12; i++) begin
      @(negedge CLK40);
      #1;
      if (i == 0) TSn = 1'b1;
    end
    checkOutput("midSlot.CPU_SLOT", CPU_SLOT, 1);
    checkOutput("midSlot.REGWRn", REGWRn, 0);
    RESET = 1'b1;
    #1;
    checkOutput("midRst.CPU_SLOT", CPU_SLOT, 0);
    checkOutput("midRst.RGAENn", RGAENn, 1);
    checkOutput("midRst.REGWRn", REGWRn, 1);
    checkOutput("midRst.DRDLE", DRDLE, 0);
    checkOutput("midRst.TACKn", TACKn, 1);
    @(negedge CLK40);
    #1;
    RESET = 1'b0;
    applyStimulus(5, 1'b0, 1'b1);
    watch(40);
    checkRun("afterRst", 9, 9, -1, 0, 18, 1, 19, 1);

`ifdef REG_TIMEOUT_EN
    // DMA owns every slot: TEAn after the fourth DMA C1R (+45), no slot, no ack
    applyStimulus(5, 1'b0, 1'b1);
    dmaUntil = slotIdx + 100;
    watch(60);
    dmaUntil = 0;
    checkRun("timeout", -1, 0, -1, 0, -1, 0, -1, 0);
    checkOutput("timeout.teaFirst", teaFirst, 45);
    checkOutput("timeout.teaCnt", teaCnt, 1);
    applyStimulus(5, 1'b0, 1'b1);
    watch(40);
    checkRun("afterTimeout", 9, 9, -1, 0, 18, 1, 19, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
